// File: rtl/core_avalon_bridge.sv
// Bridges the arm810 core start/ready bus port onto a single-word Avalon-MM master.
// Optional waitrequest timeout with sticky bus_error: define CORE_AVALON_BRIDGE_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no request outstanding; core_start is accepted
// ACCESS | Avalon request driven and held until waitrequest drops
module core_avalon_bridge #(
  parameter int ADDR_W         = 30,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_start,
  input  logic              core_write,
  input  logic [31:0]       core_data_wr,
  output logic              core_ready,
  output logic [31:0]       core_data_rd,
  output logic [31:0]       avl_address,
  output logic              avl_read,
  output logic              avl_write,
  output logic [3:0]        avl_byteenable,
  output logic [31:0]       avl_writedata,
  input  logic              avl_waitrequest,
  input  logic [31:0]       avl_readdata,
  output logic              bus_error
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] byte_addr;

  assign byte_addr = 32'({core_addr, 2'b00});

`ifdef CORE_AVALON_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Counts down the remaining stalled cycles; zero marks the last one tolerated.
  logic [CNT_W-1:0] wait_left;
  logic             bus_error_q;

  assign bus_error = bus_error_q;
`else
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      core_ready     <= 1'b0;
      core_data_rd   <= 32'h0;
      avl_address    <= 32'h0;
      avl_read       <= 1'b0;
      avl_write      <= 1'b0;
      avl_byteenable <= 4'h0;
      avl_writedata  <= 32'h0;
`ifdef CORE_AVALON_BRIDGE_TIMEOUT_EN
      wait_left      <= '0;
      bus_error_q    <= 1'b0;
`endif
    end else begin
      core_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (core_start) begin
            avl_address    <= byte_addr;
            avl_writedata  <= core_data_wr;
            avl_read       <= ~core_write;
            avl_write      <= core_write;
            avl_byteenable <= 4'hF;
            state          <= ACCESS;
`ifdef CORE_AVALON_BRIDGE_TIMEOUT_EN
            wait_left      <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        ACCESS: begin
          if (!avl_waitrequest) begin
            if (avl_read) begin
              core_data_rd <= avl_readdata;
            end
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            avl_byteenable <= 4'h0;
            core_ready     <= 1'b1;
            state          <= IDLE;
          end
`ifdef CORE_AVALON_BRIDGE_TIMEOUT_EN
          else if (wait_left == '0) begin
            // Abort: the core still gets its ready pulse, with all-ones data.
            core_data_rd   <= 32'hFFFF_FFFF;
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            avl_byteenable <= 4'h0;
            core_ready     <= 1'b1;
            bus_error_q    <= 1'b1;
            state          <= IDLE;
          end else begin
            wait_left <= wait_left - 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
